// File: rtl/f3km_sel_skid_pkg.sv
// Shared GF(3^m) field parameters: base degree, element width helpers, trit encodings.
// No logic; constants and width helpers only.
// Imported by the selector and skid blocks so every GF(3^m) block agrees on layout.
package f3km_sel_skid_pkg;

    // Default extension degree of the GF(3) base field.
    localparam int F3_M_DEF = 97;

    // Each trit is a {hi,lo} bit pair.
    localparam int TRIT_W = 2;

    // Trit encodings; 11 never represents a field value.
    localparam logic [1:0] TRIT_0   = 2'b00;
    localparam logic [1:0] TRIT_1   = 2'b01;
    localparam logic [1:0] TRIT_2   = 2'b10;
    localparam logic [1:0] TRIT_BAD = 2'b11;

    // Output buffering depth and error counter ceiling.
    localparam int         FIFO_DEPTH  = 2;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Bits in one element of GF(3^(m*k)).
    function automatic int f3_elem_w(input int m, input int k);
        return TRIT_W * m * k;
    endfunction

    // MSB index of one base-field coefficient vector (the 2*M-1 bound).
    function automatic int f3_base_msb(input int m);
        return TRIT_W * m - 1;
    endfunction

endpackage

// File: rtl/f3km_onehot_sel.sv
// One-hot channel selector with a select-legality and trit-legality check.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is sampled.
module f3km_onehot_sel
    import f3km_sel_skid_pkg::*;
#(
    parameter  int M   = F3_M_DEF,
    parameter  int K   = 2,
    parameter  int NCH = 6,
    localparam int W   = f3_elem_w(M, K)
) (
    input  logic [NCH-1:0]   sel,
    input  logic [NCH*W-1:0] in_data,
    output logic [W-1:0]     elem,
    output logic             err
);

    localparam int         NTRIT   = M * K;
    localparam logic [NCH-1:0] SEL_ONE = {{(NCH-1){1'b0}}, 1'b1};

    logic bad_trit;
    logic sel_onehot;

    // AND-OR mux: multi-hot selects still merge bitwise, zero select gives zero.
    always_comb begin
        elem = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel[c]) begin
                elem = elem | in_data[c*W +: W];
            end
        end
    end

    // Flag any 11 pair in the merged result (e.g. 01 OR 10 from a double select).
    always_comb begin
        bad_trit = 1'b0;
        for (int t = 0; t < NTRIT; t++) begin
            if (elem[TRIT_W*t +: TRIT_W] == TRIT_BAD) begin
                bad_trit = 1'b1;
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign sel_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    assign err        = ~sel_onehot | bad_trit;

endmodule

// File: rtl/f3km_sel_skid.sv
// Selects one GF(3^m) element out of NCH channels and buffers it in a 2-entry skid FIFO.
// Latency: 1 cycle from accepted input to out_valid when the FIFO is empty.
// Backpressure: in_ready is registered (occupancy < 2) and never combinational on out_ready.
module f3km_sel_skid
    import f3km_sel_skid_pkg::*;
#(
    parameter  int M   = F3_M_DEF,
    parameter  int K   = 2,
    parameter  int NCH = 6,
    localparam int W   = f3_elem_w(M, K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH-1:0]   sel,
    input  logic [NCH*W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    localparam logic [1:0] DEPTH_L = 2'(FIFO_DEPTH);

    typedef struct packed {
        logic         err;
        logic [W-1:0] dat;
    } beat_t;

    beat_t      mem_q [FIFO_DEPTH];
    beat_t      mem_d [FIFO_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       in_ready_q, in_ready_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       push;
    logic       pop;
    logic [W-1:0] sel_elem;
    logic       sel_err;
    beat_t      new_beat;

    f3km_onehot_sel #(
        .M   (M),
        .K   (K),
        .NCH (NCH)
    ) u_sel (
        .sel     (sel),
        .in_data (in_data),
        .elem    (sel_elem),
        .err     (sel_err)
    );

    assign new_beat.err = sel_err;
    assign new_beat.dat = sel_elem;

    // Handshakes: push only against the registered ready, pop whenever the head is offered.
    assign push = in_valid & in_ready_q;
    assign pop  = (cnt_q != 2'd0) & out_ready;

    // Next state of storage, pointers, occupancy, registered ready and the error counter.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_beat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Ready for next cycle follows next occupancy, so a pop while full reopens it at t+1.
        in_ready_d = (cnt_d < DEPTH_L);

        if (push && new_beat.err && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers; reset flushes every buffered beat and clears the stored data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
            err_cnt_q  <= 8'd0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q].dat;
    assign out_err   = mem_q[rd_ptr_q].err;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_f3km_sel_skid.sv
module tb_f3km_sel_skid;

    localparam int M     = 97;
    localparam int K     = 2;
    localparam int NCH   = 6;
    localparam int W     = 2 * M * K;
    localparam int K2    = 3;
    localparam int NCH2  = 8;
    localparam int W2    = 2 * M * K2;
    localparam int NBEAT = 10000;
    localparam int LIMIT = 60000;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, out_valid, out_ready, out_err;
    logic [NCH-1:0]   sel;
    logic [NCH*W-1:0] in_data;
    logic [W-1:0]     out_data;
    logic [7:0]       err_cnt;

    logic              r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_err;
    logic [NCH2-1:0]   r_sel;
    logic [NCH2*W2-1:0] r_in_data;
    logic [W2-1:0]     r_out_data;
    logic [7:0]        r_err_cnt;

    typedef struct packed {
        logic          err;
        logic [W2-1:0] dat;
    } rbeat_t;

    rbeat_t q[$];
    int     n_vec = 0;
    int     n_mis = 0;

    always #5 clk = ~clk;

    f3km_sel_skid #(.M(M), .K(K), .NCH(NCH)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt)
    );

    f3km_sel_skid #(.M(M), .K(K2), .NCH(NCH2)) u_rnd (
        .clk(clk), .reset(reset), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .sel(r_sel), .in_data(r_in_data), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .out_data(r_out_data), .out_err(r_out_err), .err_cnt(r_err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [1:0] t);
        logic [W-1:0] v;
        for (int i = 0; i < W/2; i++) v[2*i +: 2] = t;
        return v;
    endfunction

    // Channel-distinct legal pattern: trit i holds (i + c) mod 3.
    function automatic logic [W-1:0] pat(input int c);
        logic [W-1:0] v;
        for (int i = 0; i < W/2; i++) v[2*i +: 2] = 2'((i + c) % 3);
        return v;
    endfunction

    initial begin
        logic [W-1:0]           t1, t2, tbad;
        logic [NCH2*W2-1:0]     lo_all, m;
        logic [NCH2*W2+31:0]    raw;
        logic [W2-1:0]          lo2, exp_d;
        logic                   exp_e;
        rbeat_t                 hb;
        int                     sent, rcvd, cyc, ci, ti;
        logic [7:0]             exp_cnt;

        t1 = fill(2'b01);
        t2 = fill(2'b10);
        for (int i = 0; i < NCH2*W2/2; i++) lo_all[2*i +: 2] = 2'b01;
        lo2 = lo_all[W2-1:0];

        reset = 1'b0; in_valid = 1'b0; sel = '0; in_data = '0; out_ready = 1'b1;
        r_in_valid = 1'b0; r_sel = '0; r_in_data = '0; r_out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_out_err", out_err, 0);
        chkw("rst_out_data", out_data, '0);
        reset = 1'b1;

        // Basic select of channel 2
        for (int c = 0; c < NCH; c++) in_data[c*W +: W] = (c == 2) ? t1 : t2;
        sel = 6'b000100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("basic_valid", out_valid, 1);
        chkw("basic_data", out_data, t1);
        chk("basic_err", out_err, 0);
        in_valid = 1'b0;
        tick();
        chk("basic_drain", out_valid, 0);

        // Backpressure: three beats against a stalled consumer
        for (int c = 0; c < NCH; c++) in_data[c*W +: W] = pat(c);
        out_ready = 1'b0; in_valid = 1'b1; sel = 6'b000001;
        tick();
        chk("bp_rdy_after1", in_ready, 1);
        chk("bp_valid_after1", out_valid, 1);
        sel = 6'b000010;
        tick();
        chk("bp_rdy_full", in_ready, 0);
        sel = 6'b001000;
        tick();
        chk("bp_rdy_hold", in_ready, 0);
        chkw("bp_head_hold", out_data, pat(0));
        out_ready = 1'b1;
        tick();
        chk("bp_rdy_reopen", in_ready, 1);
        chkw("bp_beat2", out_data, pat(1));
        tick();
        chk("bp_valid3", out_valid, 1);
        chkw("bp_beat3", out_data, pat(3));
        in_valid = 1'b0;
        tick();
        chk("bp_empty", out_valid, 0);

        // Error cases: no select, double select, illegal trit under a legal select
        in_valid = 1'b1; sel = 6'b000000;
        tick();
        chkw("zero_sel_data", out_data, '0);
        chk("zero_sel_err", out_err, 1);
        chk("zero_sel_cnt", err_cnt, 1);
        in_data = '0;
        in_data[0*W +: W] = t1;
        in_data[5*W +: W] = t2;
        sel = 6'b100001;
        tick();
        chkw("multi_data", out_data, fill(2'b11));
        chk("multi_err", out_err, 1);
        chk("multi_cnt", err_cnt, 2);
        tbad = t1;
        tbad[11:10] = 2'b11;
        in_data[1*W +: W] = tbad;
        sel = 6'b000010;
        tick();
        chkw("badtrit_data", out_data, tbad);
        chk("badtrit_err", out_err, 1);
        chk("badtrit_cnt", err_cnt, 3);

        // Saturation of the error counter
        sel = 6'b000000;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 199) chk("sat_mid", err_cnt, 203);
        end
        chk("sat_top", err_cnt, 255);
        in_valid = 1'b0;
        tick(); tick();
        chk("sat_stay", err_cnt, 255);
        chk("sat_drained", out_valid, 0);

        // Reset while full
        for (int c = 0; c < NCH; c++) in_data[c*W +: W] = pat(c);
        out_ready = 1'b0; in_valid = 1'b1; sel = 6'b000001;
        tick();
        sel = 6'b000010;
        tick();
        chk("mid_full_rdy", in_ready, 0);
        chk("mid_full_valid", out_valid, 1);
        in_valid = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1; out_ready = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_rdy", in_ready, 1);
        chk("mid_rst_cnt", err_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_rst_quiet", out_valid, 0);
        end

        // Random traffic on the K=3, NCH=8 instance against a queue model
        sent = 0; rcvd = 0; cyc = 0; exp_cnt = 8'd0;
        while (rcvd < NBEAT && cyc < LIMIT) begin
            r_in_valid  = (sent < NBEAT) && ($urandom_range(0, 1) == 1);
            r_out_ready = ($urandom_range(0, 1) == 1);
            for (int j = 0; j < NCH2*W2; j += 32) raw[j +: 32] = $urandom;
            m = raw[NCH2*W2-1:0] & (raw[NCH2*W2-1:0] >> 1) & lo_all;
            r_in_data = raw[NCH2*W2-1:0] & ~(m | (m << 1));
            ci = $urandom_range(0, NCH2-1);
            if ($urandom_range(0, 7) == 0) r_sel = 8'($urandom);
            else                           r_sel = 8'b1 << ci;
            if ($urandom_range(0, 15) == 0) begin
                ti = $urandom_range(0, W2/2 - 1);
                r_in_data[ci*W2 + 2*ti +: 2] = 2'b11;
            end

            if (r_out_valid && r_out_ready) begin
                n_vec++;
                assert (q.size() != 0) else begin
                    n_mis++;
                    $error("FAIL rnd_extra_beat observed=%0d queued expected>0", q.size());
                end
                if (q.size() != 0) begin
                    hb = q.pop_front();
                    n_vec++;
                    assert (r_out_data === hb.dat) else begin
                        n_mis++;
                        $error("FAIL rnd_data beat=%0d observed=%0h expected=%0h", rcvd, r_out_data, hb.dat);
                    end
                    n_vec++;
                    assert (r_out_err === hb.err) else begin
                        n_mis++;
                        $error("FAIL rnd_err beat=%0d observed=%0b expected=%0b", rcvd, r_out_err, hb.err);
                    end
                end
                rcvd++;
            end

            if (r_in_valid && r_in_ready) begin
                exp_d = '0;
                for (int c = 0; c < NCH2; c++)
                    if (r_sel[c]) exp_d = exp_d | r_in_data[c*W2 +: W2];
                exp_e = !$onehot(r_sel) || ((exp_d & (exp_d >> 1) & lo2) != '0);
                q.push_back('{err: exp_e, dat: exp_d});
                if (exp_e && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
                sent++;
            end

            tick();
            cyc++;
        end
        r_in_valid = 1'b0;
        r_out_ready = 1'b1;
        tick();
        chk("rnd_received", rcvd, NBEAT);
        chk("rnd_sent", sent, NBEAT);
        chk("rnd_queue_left", q.size(), 0);
        chk("rnd_no_extra", r_out_valid, 0);
        chk("rnd_err_cnt", r_err_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/f3km_sel_skid.md
F3KM_SEL_SKID -- requirements
Module: f3km_sel_skid

Interface
REQ-001 SHALL have parameter M, 97, GF(3) extension degree of the base field.
REQ-002 SHALL have parameter K, 2, tower degree with legal values 1, 2, 3 or 6; element width W = 2*M*K bits.
REQ-003 SHALL have parameter NCH, 6, number of input channels with legal range 2..8.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1, input beat offered.
REQ-007 SHALL have port in_ready, output, 1, input beat accepted when in_valid & in_ready.
REQ-008 SHALL have port sel, input, NCH, one-hot channel select.
REQ-009 SHALL have port in_data, input, NCH*W, channel c at bits [c*W +: W].
REQ-010 SHALL have port out_valid, output, 1, output beat present.
REQ-011 SHALL have port out_ready, input, 1, output beat consumed when out_valid & out_ready.
REQ-012 SHALL have port out_data, output, W, selected element.
REQ-013 SHALL have port out_err, output, 1, error flag travelling with out_data.
REQ-014 SHALL have port err_cnt, output, 8, saturating count of accepted erroneous beats.

Function
REQ-015 Each trit SHALL be a 2-bit pair {hi,lo} with 00=0, 01=1, 10=2; 11 is illegal.
REQ-016 Selection SHALL be out = OR over c of (in_data[c] AND sel[c]), computed bitwise per element.
REQ-017 out_err for a beat SHALL be 1 when sel is not exactly one-hot (zero bits or two or more), or when any trit of the selected result is 11.
REQ-018 sel = 0 SHALL yield an all-zero element with out_err = 1.
REQ-019 Multi-hot sel SHALL still yield the bitwise OR, with out_err = 1.
REQ-020 Accepted beats SHALL be held in a 2-entry FIFO storing {out_err, out_data}; head drives out_data/out_err.
REQ-021 Latency SHALL be 1 cycle: a beat accepted in cycle t appears with out_valid = 1 in cycle t+1 if the FIFO was empty.
REQ-022 in_ready SHALL be a registered signal equal to (occupancy < 2); it SHALL NOT depend combinationally on out_ready.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; order SHALL be strictly FIFO.
REQ-024 When full and out_ready = 0, in_ready = 0 and the FIFO contents SHALL hold.
REQ-025 When full and out_ready = 1 in cycle t, in_ready SHALL be 1 in cycle t+1.
REQ-026 out_valid = 0 SHALL occur only when the FIFO is empty; out_data SHALL be ignored by consumers then and is don't-care.
REQ-027 err_cnt SHALL increment by 1 on each accepted beat with out_err = 1 and saturate at 255.
REQ-028 in_data and sel SHALL be sampled only on an accepted handshake.

Reset
REQ-029 With reset = 0 at a rising edge: occupancy = 0, out_valid = 0, in_ready = 1 on the next cycle, err_cnt = 0, out_err = 0, out_data = 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered beats; no beat SHALL emerge after reset release without a new handshake.

Structure
REQ-031 M, the width macros (W, 2*M-1 style bounds) and the trit encoding constants SHALL live in the shared field-parameter package/include used by the other GF(3^m) blocks.
REQ-032 The combinational selector-plus-check SHALL be one sub-module, f3km_onehot_sel (sel, in_data -> element, err); the FIFO, handshake and counter SHALL be in f3km_sel_skid.

Verification
REQ-033 M=97, K=2, NCH=6; sel=000100, channel 2 = all trits 01, others 10; out_ready=1 -> next cycle out_valid=1, out_data all 01, out_err=0.
REQ-034 Hold out_ready=0; push 3 beats back-to-back -> first two accepted, in_ready=0 from cycle 2, the third is held; release out_ready -> beats 1, 2, 3 emerge in order.
REQ-035 sel=000000 -> out_data=0, out_err=1, err_cnt=1; sel=100001 with ch0=01.., ch5=10.. -> all trits 11, out_err=1, err_cnt=2.
REQ-036 Send 300 erroneous beats -> err_cnt saturates at 255 and stays there.
REQ-037 Bring occupancy to 2, assert reset=0 for 1 cycle -> next cycle out_valid=0, in_ready=1, err_cnt=0; with no new input, no output appears.
REQ-038 Random in_valid/out_ready at 50% over 10k beats, K in {1,3,6}, NCH in {2,8} -> output stream equals scoreboard model and no beat is lost or duplicated.
